// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready handshakes; one operand slice per stage.
// Optional CSA_OVF_EN adds a registered signed-overflow output (ovf) aligned with sum.
module carry_skip_adder_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SLICE = WIDTH / STAGES;
  localparam int unsigned NBLK  = SLICE / BLOCK;

  if (((WIDTH % STAGES) != 0) || ((SLICE % BLOCK) != 0)) begin : g_cfg_err
    $error("carry_skip_adder_pipe: WIDTH must split into STAGES slices of whole BLOCKs");
  end

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [STAGES-1:0] v_q, v_d, c_q, c_d;

  // Stage inputs: stage 0 sees the (inverted-for-subtract) ports, later stages the previous register.
  logic [WIDTH-1:0] a_x [STAGES];
  logic [WIDTH-1:0] b_x [STAGES];
  logic [WIDTH-1:0] s_x [STAGES];
  logic [STAGES-1:0] v_x, c_x;

  logic stall;

  assign a_x[0] = a;
  assign b_x[0] = sub ? ~b : b;
  assign s_x[0] = '0;
  assign c_x[0] = sub | cin;
  assign v_x[0] = in_valid;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign a_x[k] = a_q[k-1];
    assign b_x[k] = b_q[k-1];
    assign s_x[k] = s_q[k-1];
    assign c_x[k] = c_q[k-1];
    assign v_x[k] = v_q[k-1];
  end

  assign stall     = v_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

`ifdef CSA_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif

  always_comb begin
    logic        ci, rip, bcin, prop, p, cmsb;
    int unsigned idx;
    ci   = 1'b0;
    rip  = 1'b0;
    bcin = 1'b0;
    prop = 1'b0;
    p    = 1'b0;
    cmsb = 1'b0;
    idx  = 0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      s_d[k] = s_x[k];
      a_d[k] = a_x[k];
      b_d[k] = b_x[k];
      v_d[k] = v_x[k];
      ci     = c_x[k];
      for (int unsigned blk = 0; blk < NBLK; blk++) begin
        bcin = ci;
        rip  = ci;
        prop = 1'b1;
        for (int unsigned j = 0; j < BLOCK; j++) begin
          idx = k * SLICE + blk * BLOCK + j;
          p   = a_x[k][idx] ^ b_x[k][idx];
          if (idx == WIDTH - 1) cmsb = rip;
          s_d[k][idx] = p ^ rip;
          rip  = (a_x[k][idx] & b_x[k][idx]) | (p & rip);
          prop = prop & p;
        end
        // Skip path: a fully propagating block passes its carry-in straight through.
        ci = prop ? bcin : rip;
      end
      c_d[k] = ci;
    end
`ifdef CSA_OVF_EN
    ovf_d = cmsb ^ c_d[STAGES-1];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      s_q <= '{default: '0};
`ifdef CSA_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (!stall) begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
`ifdef CSA_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Directed self-checking bench for carry_skip_adder_pipe (WIDTH=32, BLOCK=4, STAGES=2).
module tb_carry_skip_adder_pipe;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CSA_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  carry_skip_adder_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: accepted on the first edge, visible after the second.
  task automatic run_one(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic sb,
                         input logic [W-1:0] es, input logic ec);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk({tag, ".lat1_valid"}, W'(out_valid), W'(1'b0));
    tick;
    chk({tag, ".valid"}, W'(out_valid), W'(1'b1));
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, W'(cout), W'(ec));
    chk({tag, ".in_ready"}, W'(in_ready), W'(1'b1));
  endtask

  initial begin
    // Reset held for three cycles with a beat offered.
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst.out_valid", W'(out_valid), W'(1'b0));
      chk("rst.sum", sum, 32'h0);
      chk("rst.cout", W'(cout), W'(1'b0));
      chk("rst.in_ready", W'(in_ready), W'(1'b1));
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick;
    chk("post_rst.out_valid", W'(out_valid), W'(1'b0));

    run_one("skip_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
`ifdef CSA_OVF_EN
    chk("skip_chain.ovf", W'(ovf), W'(1'b0));
`endif
    run_one("prop_cin1", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
    run_one("prop_cin0", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_one("sub_cin0", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
`ifdef CSA_OVF_EN
    chk("sub_cin0.ovf", W'(ovf), W'(1'b0));
`endif
    run_one("sub_cin1", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_one("sub_ge", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
    run_one("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
`ifdef CSA_OVF_EN
    chk("ovf_add.ovf", W'(ovf), W'(1'b1));
`endif
    run_one("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
`ifdef CSA_OVF_EN
    chk("ovf_sub.ovf", W'(ovf), W'(1'b1));
`endif
    tick;
    chk("idle.out_valid", W'(out_valid), W'(1'b0));

    // Backpressure: three back-to-back beats, consumer stalls for three edges.
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick;
    chk("bp.e1_valid", W'(out_valid), W'(1'b0));
    a = 32'h0F0F_0F0F; b = 32'hF0F0_F0F0; cin = 1'b1; out_ready = 1'b0;
    tick;
    chk("bp.e2_valid", W'(out_valid), W'(1'b1));
    chk("bp.e2_sum", sum, 32'h2345_6789);
    chk("bp.e2_in_ready", W'(in_ready), W'(1'b0));
    a = 32'h0000_0001; b = 32'h0000_0002; cin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("bp.hold_valid", W'(out_valid), W'(1'b1));
      chk("bp.hold_sum", sum, 32'h2345_6789);
      chk("bp.hold_cout", W'(cout), W'(1'b0));
      chk("bp.hold_in_ready", W'(in_ready), W'(1'b0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_in_ready", W'(in_ready), W'(1'b1));
    tick;
    in_valid = 1'b0;
    chk("bp.y_valid", W'(out_valid), W'(1'b1));
    chk("bp.y_sum", sum, 32'h0000_0000);
    chk("bp.y_cout", W'(cout), W'(1'b1));
    tick;
    chk("bp.z_valid", W'(out_valid), W'(1'b1));
    chk("bp.z_sum", sum, 32'h0000_0003);
    chk("bp.z_cout", W'(cout), W'(1'b0));
    tick;
    chk("bp.drained", W'(out_valid), W'(1'b0));

    // Mid-operation reset discards in-flight beats.
    a = 32'h0000_0010; b = 32'h0000_0020; in_valid = 1'b1;
    tick;
    a = 32'h0000_0030; b = 32'h0000_0040;
    tick;
    in_valid = 1'b0;
    chk("mid.pre_valid", W'(out_valid), W'(1'b1));
    chk("mid.pre_sum", sum, 32'h0000_0030);
    rst = 1'b1;
    #1;
    chk("mid.async_valid", W'(out_valid), W'(1'b0));
    chk("mid.async_sum", sum, 32'h0);
    chk("mid.async_in_ready", W'(in_ready), W'(1'b1));
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("mid.no_stale", W'(out_valid), W'(1'b0));
    end

    run_one("recover", 32'h0000_0100, 32'h0000_0023, 1'b1, 1'b0, 32'h0000_0124, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
